vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: display pixel fetch from the VGA timing generator, and a drawing-engine write port.
- Display fetch has absolute priority; writes and a hardware clear-screen sweep use the remaining cycles.
- Sits between the timing generator (x/y/xyvalid/yvalid/syncs) and the RGB pins, and returns colour and sync outputs aligned to each other.

Parameters:
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines.
- SCALE_SHIFT, 2: log2 of the pixel replication factor. The framebuffer is (H_RES>>SCALE_SHIFT) x (V_RES>>SCALE_SHIFT).
- DATA_W, 12: RGB 4:4:4 word width.
- ADDR_W, 15: RAM address width.
- FB_DEPTH, 19200: number of framebuffer words, equal to (H_RES>>SCALE_SHIFT)*(V_RES>>SCALE_SHIFT).

Ports:
- clk, in, 1: system clock, 100 MHz.
- clr, in, 1: reset. Synchronous, active-high.
- clk_25MHz, in, 1: pixel strobe, high for one clk per pixel.
- xyvalid, in, 1: active-video flag from the timing generator.
- yvalid, in, 1: active-line flag.
- x, in, 10: active-area pixel column.
- y, in, 10: active-area line.
- hsync_in, in, 1: horizontal sync, active-low.
- vsync_in, in, 1: vertical sync, active-low.
- wr_valid, in, 1: write request.
- wr_ready, out, 1: write accepted this cycle.
- wr_addr, in, ADDR_W: write address.
- wr_data, in, DATA_W: write data.
- clear_req, in, 1: start clear-screen sweep.
- clear_color, in, DATA_W: fill colour, sampled with clear_req.
- busy, out, 1: clear sweep in progress.
- clear_done, out, 1: one-clk pulse when the sweep completes.
- vblank_start, out, 1: one-clk pulse when yvalid falls 1->0.
- mem_en, out, 1: RAM enable.
- mem_we, out, 1: RAM write enable.
- mem_addr, out, ADDR_W: RAM address.
- mem_wdata, out, DATA_W: RAM write data.
- mem_rdata, in, DATA_W: RAM read data, valid one clk after the read.
- rgb_out, out, DATA_W: pixel colour to the pins.
- hsync_out, out, 1: delayed horizontal sync.
- vsync_out, out, 1: delayed vertical sync.

Behaviour:
- Display slot:
  - disp = clk_25MHz & xyvalid.
  - In a disp cycle: mem_en=1, mem_we=0, mem_addr=(y>>SCALE_SHIFT)*(H_RES>>SCALE_SHIFT)+(x>>SCALE_SHIFT).
  - Compute the product at full width, then truncate to ADDR_W.
- Non-display cycle, FSM IDLE:
  - wr_ready=1.
  - If wr_valid: mem_en=1, mem_we=(wr_addr<FB_DEPTH), mem_addr=wr_addr, mem_wdata=wr_data.
  - Out-of-range writes are handshaked and dropped.
- Any disp cycle: wr_ready=0 and no write issued. A requester holds wr_valid/addr/data until wr_ready=1.
- wr_ready, mem_en, mem_we, mem_addr and mem_wdata are combinational from current state and inputs.
- Read pipeline:
  - Stage flop vld_d <= disp.
  - rgb_out <= vld_d ? mem_rdata : 0.
  - rgb_out reflects the pixel 2 clk after its disp cycle. Blanking outputs 0 (0 is also loaded for any non-disp cycle).
  - hsync_in and vsync_in pass through 2-flop delay lines so they align with rgb_out.
- FSM IDLE/CLEAR:
  - IDLE & clear_req: go to CLEAR, cnt<=0, latch clear_color.
  - CLEAR, each non-disp cycle: write latched colour at cnt, cnt++.
  - After the write at cnt==FB_DEPTH-1: go to IDLE, clear_done=1 for one clk.
  - CLEAR: busy=1 and wr_ready=0. clear_req is ignored.
  - A disp cycle stalls the sweep; cnt holds.
- vblank_start: registered, 1 for one clk after the clk edge where yvalid_d=1 and yvalid=0.
- Reset (sync, any state including mid-sweep):
  - FSM=IDLE, cnt=0, busy=0, clear_done=0, vblank_start=0, vld_d=0, rgb_out=0.
  - Sync delay flops = 1 (inactive).
  - An aborted sweep never pulses clear_done.

Test Plan:
- Reset: assert clr 1 clk with clk_25MHz=0. Required: rgb_out=0, busy=0, clear_done=0, hsync_out=vsync_out=1, wr_ready=1.
- Write-then-display: during blank, write addr 0 = 12'hF00. Then x=0, y=0, xyvalid=1, clk_25MHz pulse. Required: mem_addr=0 that clk, rgb_out=12'hF00 exactly 2 clk later, and 0 for a non-valid pixel.
- Address scaling: x=5, y=9, SCALE_SHIFT=2, disp. Required: mem_addr=2*160+1=321. Also x=639, y=479 gives mem_addr=19199.
- Collision: wr_valid held with addr 100 across a disp cycle. Required: wr_ready=0 and mem_we=0 that clk; the write lands the next clk with wr_ready=1 and mem_addr=100. Out-of-range addr 19200: wr_ready=1, mem_we=0.
- Clear:
  - Setup: clear_req with 12'h00F, xyvalid=0.
  - Required: busy=1 for 19200 clk; clear_done pulses on the clk after the final write; readback of 0, 9600 and 19199 all gives 12'h00F.
  - A second clear_req mid-sweep is ignored.
  - With displays interleaved, total sweep = 19200 + number of disp cycles.
- Reset mid-clear and vblank:
  - clr at cnt=500. Required: busy=0 next clk, no clear_done, then a new clear_req restarts at 0.
  - yvalid 1->0. Required: vblank_start high exactly 1 clk.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares one single-port synchronous RAM between VGA
// pixel fetch (absolute priority), a drawing-engine write port and a
// hardware clear-screen sweep. Colour and syncs leave aligned, 2 clk late.
//
// Write handshake: a write transfers on a cycle where wr_valid and wr_ready
// are both high. The requester holds wr_valid/wr_addr/wr_data stable until
// then. wr_ready is low in any display cycle and throughout a clear sweep.
// Accepted writes with wr_addr >= FB_DEPTH are acknowledged but dropped.
module vga_fb_arbiter #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int DATA_W      = 12,
  parameter int ADDR_W      = 15,
  parameter int FB_DEPTH    = 19200
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clk_25MHz,
  input  logic              xyvalid,
  input  logic              yvalid,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_color,
  output logic              busy,
  output logic              clear_done,
  output logic              vblank_start,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rgb_out,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam int FB_COLS = H_RES >> SCALE_SHIFT;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FB_DEPTH - 1);

  // busy is a direct decode of the state register, so it doubles as the
  // externally visible FSM state.
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] clear_col;
  logic              disp;
  logic [31:0]       disp_prod;
  logic [ADDR_W-1:0] disp_addr;
  logic              last_write;
  logic              vld_d;
  logic              hs_d, vs_d;
  logic              yvalid_d;

  // Display slot decode and scaled framebuffer address (full-width product,
  // then truncated to the RAM address width).
  always_comb begin
    disp      = clk_25MHz & xyvalid;
    disp_prod = 32'(y >> SCALE_SHIFT) * 32'(FB_COLS) + 32'(x >> SCALE_SHIFT);
    disp_addr = disp_prod[ADDR_W-1:0];
  end

  // Next state and RAM port mux: display first, then sweep or write port.
  always_comb begin
    state_nxt  = state;
    wr_ready   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    last_write = 1'b0;
    busy       = (state == CLEAR);
    case (state)
      IDLE: if (clear_req) state_nxt = CLEAR;
      CLEAR: begin
        last_write = !disp && (cnt == LAST_A);
        if (last_write) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (disp) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (state == IDLE) begin
      wr_ready = 1'b1;
      if (wr_valid) begin
        mem_en    = 1'b1;
        mem_we    = (wr_addr < DEPTH_A);
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end else begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cnt;
      mem_wdata = clear_col;
    end
  end

  // State register, sweep counter, latched fill colour and done pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      cnt        <= '0;
      clear_col  <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clear_done <= last_write;
      if (state == IDLE && clear_req) begin
        cnt       <= '0;
        clear_col <= clear_color;
      end else if (state == CLEAR && !disp) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Read-data pipeline and sync delay lines, aligned to rgb_out.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_d     <= 1'b0;
      rgb_out   <= '0;
      hs_d      <= 1'b1;
      hsync_out <= 1'b1;
      vs_d      <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      vld_d     <= disp;
      rgb_out   <= vld_d ? mem_rdata : '0;
      hs_d      <= hsync_in;
      hsync_out <= hs_d;
      vs_d      <= vsync_in;
      vsync_out <= vs_d;
    end
  end

  // One-clk pulse on the falling edge of the active-line flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      yvalid_d     <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      yvalid_d     <= yvalid;
      vblank_start <= yvalid_d & ~yvalid;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed steps followed by randomized traffic
// checked against a framebuffer-level reference model.
module tb_vga_fb_arbiter;

  localparam int DW = 12;
  localparam int AW = 15;
  localparam int DEPTH = 19200;
  localparam int COLS = 160;

  logic          clk = 1'b0;
  logic          clr, clk_25MHz, xyvalid, yvalid;
  logic [9:0]    x, y;
  logic          hsync_in, vsync_in;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clear_req;
  logic [DW-1:0] clear_color;
  logic          busy, clear_done, vblank_start;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] rgb_out;
  logic          hsync_out, vsync_out;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] fb_model [0:DEPTH-1];
  logic [13:0]   exp_q[$];

  vga_fb_arbiter dut (
    .clk(clk), .clr(clr), .clk_25MHz(clk_25MHz), .xyvalid(xyvalid),
    .yvalid(yvalid), .x(x), .y(y), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .clear_req(clear_req), .clear_color(clear_color),
    .busy(busy), .clear_done(clear_done), .vblank_start(vblank_start),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb_out(rgb_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // synchronous single-port RAM, read data one clk after the access
  always @(posedge clk) begin
    if (mem_en && mem_addr < AW'(DEPTH)) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_idle();
    clr = 1'b0; clk_25MHz = 1'b0; xyvalid = 1'b0; yvalid = 1'b0;
    x = '0; y = '0; hsync_in = 1'b1; vsync_in = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clear_req = 1'b0; clear_color = '0;
  endtask

  task automatic disp_px(input int px, input int py);
    set_idle();
    clk_25MHz = 1'b1; xyvalid = 1'b1; x = 10'(px); y = 10'(py);
    settle();
    check("disp_addr", mem_addr, (py / 4) * COLS + px / 4);
    tick();
  endtask

  // Full sweep with a disp cycle every disp_every cycles (0 = none) and a
  // stray clear_req mid-sweep that must be ignored.
  task automatic run_clear(input logic [DW-1:0] col, input int disp_every);
    int n, nd, writes;
    set_idle();
    clear_req = 1'b1; clear_color = col;
    settle();
    check("clr_busy_before", busy, 0);
    tick();
    clear_req = 1'b0;
    check("clr_busy_start", busy, 1);
    n = 0; nd = 0; writes = 0;
    while (busy && n < 40000) begin
      set_idle();
      if (n == 5000) begin clear_req = 1'b1; clear_color = 12'hABC; end
      if (disp_every > 0 && (n % disp_every) == disp_every - 1) begin
        clk_25MHz = 1'b1; xyvalid = 1'b1;
        x = 10'($urandom_range(0, 639)); y = 10'($urandom_range(0, 479));
      end
      settle();
      if (clk_25MHz) begin
        check("clr_disp_no_we", mem_we, 0);
        nd++;
      end else begin
        check("clr_addr", mem_addr, writes);
        check("clr_wdata", mem_wdata, col);
        writes++;
      end
      if (n == 5000) check("clr_ignore_ready", wr_ready, 0);
      tick();
      n++;
    end
    check("clr_len", n, DEPTH + nd);
    check("clr_done_pulse", clear_done, 1);
    set_idle();
    tick();
    check("clr_done_low", clear_done, 0);
    check("clr_busy_end", busy, 0);
    for (int i = 0; i < DEPTH; i++) fb_model[i] = col;
  endtask

  initial begin
    logic          rdisp, rprev_yv, accepted;
    logic [AW-1:0] raddr;
    logic [13:0]   e;

    // reset with syncs driven low to expose the reset value of the delay line
    set_idle();
    clr = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    check("rst_rgb", rgb_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_hs", hsync_out, 1);
    check("rst_vs", vsync_out, 1);
    check("rst_wr_ready", wr_ready, 1);
    set_idle();
    tick(); tick();

    // write during blank, then display the same pixel
    set_idle();
    wr_valid = 1'b1; wr_addr = '0; wr_data = 12'hF00;
    settle();
    check("wd_ready", wr_ready, 1);
    check("wd_we", mem_we, 1);
    check("wd_addr", mem_addr, 0);
    tick();
    disp_px(0, 0);
    set_idle(); xyvalid = 1'b1;
    tick();
    check("wd_rgb", rgb_out, 12'hF00);
    tick();
    check("wd_rgb_blank", rgb_out, 0);

    // address scaling, including the last pixel
    disp_px(5, 9);
    set_idle(); clk_25MHz = 1'b1; xyvalid = 1'b1; x = 10'd5; y = 10'd9;
    settle();
    check("scale_321", mem_addr, 321);
    x = 10'd639; y = 10'd479;
    settle();
    check("scale_19199", mem_addr, 19199);
    tick();

    // collision: write held across a display cycle
    set_idle();
    wr_valid = 1'b1; wr_addr = 15'd100; wr_data = 12'h5A5;
    clk_25MHz = 1'b1; xyvalid = 1'b1; x = 10'd8; y = 10'd8;
    settle();
    check("col_ready_low", wr_ready, 0);
    check("col_we_low", mem_we, 0);
    check("col_disp_addr", mem_addr, 322);
    tick();
    clk_25MHz = 1'b0;
    settle();
    check("col_ready_high", wr_ready, 1);
    check("col_we_high", mem_we, 1);
    check("col_addr", mem_addr, 100);
    check("col_wdata", mem_wdata, 12'h5A5);
    tick();
    set_idle();
    wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 12'hFFF;
    settle();
    check("oor_ready", wr_ready, 1);
    check("oor_we", mem_we, 0);
    tick();

    // plain clear sweep and readback
    run_clear(12'h00F, 0);
    disp_px(0, 0);
    disp_px(0, 240);
    check("rb_0", rgb_out, 12'h00F);
    disp_px(639, 479);
    check("rb_9600", rgb_out, 12'h00F);
    set_idle();
    tick();
    check("rb_19199", rgb_out, 12'h00F);

    // vblank pulse
    set_idle(); yvalid = 1'b1;
    tick();
    check("vb_idle", vblank_start, 0);
    yvalid = 1'b0;
    tick();
    check("vb_pulse", vblank_start, 1);
    tick();
    check("vb_low", vblank_start, 0);

    // sweep with displays interleaved
    run_clear(12'h0A5, 4);

    // reset in the middle of a sweep, then restart
    set_idle();
    clear_req = 1'b1; clear_color = 12'h777;
    tick();
    for (int i = 0; i < 500; i++) begin
      set_idle();
      tick();
    end
    set_idle(); clr = 1'b1;
    settle();
    check("mid_cnt_500", mem_addr, 500);
    tick();
    clr = 1'b0;
    check("mid_busy", busy, 0);
    check("mid_done", clear_done, 0);
    for (int i = 0; i < 4; i++) begin
      set_idle();
      settle();
      check("abort_no_en", mem_en, 0);
      tick();
      check("abort_no_done", clear_done, 0);
    end
    run_clear(12'h777, 0);

    // randomized traffic against the framebuffer model
    set_idle();
    tick();
    exp_q.delete();
    exp_q.push_back({1'b1, 1'b1, 12'h000});
    rprev_yv = 1'b0;
    wr_valid = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      clk_25MHz = ($urandom_range(0, 2) == 0);
      xyvalid   = ($urandom_range(0, 3) != 0);
      yvalid    = ($urandom_range(0, 7) != 0);
      x = 10'($urandom_range(0, 639));
      y = 10'($urandom_range(0, 479));
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      if (!wr_valid) begin
        wr_valid = ($urandom_range(0, 1) == 1);
        wr_addr  = 15'($urandom_range(0, 19300));
        wr_data  = 12'($urandom);
      end
      settle();
      rdisp = clk_25MHz & xyvalid;
      raddr = AW'((int'(y) / 4) * COLS + int'(x) / 4);
      check("rnd_ready", wr_ready, !rdisp);
      check("rnd_en", mem_en, rdisp | wr_valid);
      if (rdisp) begin
        check("rnd_disp_addr", mem_addr, raddr);
        check("rnd_disp_we", mem_we, 0);
      end else if (wr_valid) begin
        check("rnd_wr_addr", mem_addr, wr_addr);
        check("rnd_wr_we", mem_we, wr_addr < AW'(DEPTH));
        check("rnd_wr_data", mem_wdata, wr_data);
      end
      exp_q.push_back({hsync_in, vsync_in, rdisp ? fb_model[raddr] : 12'h000});
      accepted = !rdisp && wr_valid;
      if (accepted && wr_addr < AW'(DEPTH)) fb_model[wr_addr] = wr_data;
      tick();
      e = exp_q.pop_front();
      check("rnd_rgb", rgb_out, e[11:0]);
      check("rnd_hs", hsync_out, e[13]);
      check("rnd_vs", vsync_out, e[12]);
      check("rnd_vblank", vblank_start, rprev_yv & ~yvalid);
      rprev_yv = yvalid;
      if (accepted) wr_valid = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
